// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush controller: detects RAW hazards against EXE/MEM, inserts
// bubbles, flushes on taken branches, and freezes the pipe while data memory is busy.
//
// state     | meaning
// ----------+----------------------------------------------
// RUN       | normal issue, no bubble pending
// STALL     | previous cycle inserted a load-use / RAW bubble
// MEM_WAIT  | data memory busy, pipe frozen, timeout counting
module hazard_flush_ctrl #(
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       exe_dst,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dst,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [7:0]       WAIT_LIMIT = 8'(TIMEOUT);
    localparam logic [7:0]       WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state_q;
    state_t     state_d;
    logic       kill_q;
    logic [7:0] wait_cnt;

    logic raw_exe;
    logic raw_mem;
    logic hz;
    logic stall_req;
    logic bubble_evt;
    logic flush_evt;
    logic wait_inc;

    assign state = state_q;

    always_comb begin
        raw_exe = exe_wb_en && ((exe_dst == src1) || (two_src && (exe_dst == src2)));
        raw_mem = mem_wb_en && ((mem_dst == src1) || (two_src && (mem_dst == src2)));
        if (FWD_EN != 0) begin
            hz = raw_exe && exe_mem_r_en;
        end else begin
            hz = raw_exe || raw_mem;
        end
        // A slot that was just flushed holds no real instruction, so it cannot stall.
        stall_req = hz && !kill_q;
    end

    always_comb begin
        pc_freeze    = 1'b0;
        if_id_freeze = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        bubble_evt   = 1'b0;
        flush_evt    = 1'b0;

        if (mem_busy) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            pipe_freeze  = 1'b1;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            flush_evt    = 1'b1;
        end else if (stall_req) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_ex_flush  = 1'b1;
            bubble_evt   = 1'b1;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (mem_busy) begin
            state_d = ST_MEM_WAIT;
        end else if (stall_req && !branch_taken) begin
            state_d = ST_STALL;
        end
    end

    assign wait_inc = (state_q == ST_MEM_WAIT) && mem_busy && (wait_cnt != WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!if_id_freeze) begin
                kill_q <= if_id_flush;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            if (state_q != ST_MEM_WAIT) begin
                wait_cnt <= 8'd0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            // Sticky: only reset clears it.
            if (wait_inc && (wait_cnt == WAIT_LAST)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bubble_evt && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_evt && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: scoreboard of expected control/state/counter
// values against a forwarding DUT, plus direct checks on a no-forwarding instance.
module tb_hazard_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  src1, src2, exe_dst, mem_dst;
    logic        two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_busy;

    logic        pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        nf_pc_freeze, nf_if_id_freeze, nf_if_id_flush, nf_id_ex_flush, nf_pipe_freeze;
    logic        nf_mem_timeout;
    logic [1:0]  nf_state;
    logic [15:0] nf_stall_cnt, nf_flush_cnt;

    always #5 clk = ~clk;

    hazard_flush_ctrl #(.FWD_EN(1), .CNT_W(16), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dst(exe_dst),
        .mem_wb_en(mem_wb_en), .mem_dst(mem_dst), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    hazard_flush_ctrl #(.FWD_EN(0), .CNT_W(16), .TIMEOUT(64)) u_dut_nf (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dst(exe_dst),
        .mem_wb_en(mem_wb_en), .mem_dst(mem_dst), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_freeze(nf_pc_freeze), .if_id_freeze(nf_if_id_freeze),
        .if_id_flush(nf_if_id_flush), .id_ex_flush(nf_id_ex_flush), .pipe_freeze(nf_pipe_freeze),
        .state(nf_state), .stall_cnt(nf_stall_cnt), .flush_cnt(nf_flush_cnt),
        .mem_timeout(nf_mem_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // ctl bit order: {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze}
    typedef struct packed {
        logic [4:0]  ctl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb_q[$];

    logic        m_kill;
    logic [1:0]  m_state;
    logic [15:0] m_stall, m_flush;

    task automatic model_reset();
        m_kill  = 1'b0;
        m_state = 2'd0;
        m_stall = 16'd0;
        m_flush = 16'd0;
    endtask

    task automatic set_idle();
        src1 = 4'd0; src2 = 4'd0; two_src = 1'b0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dst = 4'd0;
        mem_wb_en = 1'b0; mem_dst = 4'd0; branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input string tag, input bit chk);
        logic       hz, sreq;
        logic [4:0] ctl, got;
        exp_t       e;
        hz   = exe_wb_en && exe_mem_r_en && ((exe_dst == src1) || (two_src && (exe_dst == src2)));
        sreq = hz && !m_kill;
        ctl  = 5'b00000;
        if (mem_busy)          ctl = 5'b11001;
        else if (branch_taken) ctl = 5'b00110;
        else if (sreq)         ctl = 5'b11010;
        if (!mem_busy && !branch_taken && sreq && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
        if (!mem_busy && branch_taken && (m_flush != 16'hFFFF)) m_flush = m_flush + 16'd1;
        if (!ctl[3]) m_kill = ctl[2];
        m_state = mem_busy ? 2'd2 : ((sreq && !branch_taken) ? 2'd1 : 2'd0);
        e.ctl = ctl; e.st = m_state; e.sc = m_stall; e.fc = m_flush;
        sb_q.push_back(e);
        #1;
        got = {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze};
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (chk) begin
            check({tag, ".ctl"},   32'(got),       32'(e.ctl));
            check({tag, ".state"}, 32'(state),     32'(e.st));
            check({tag, ".stall"}, 32'(stall_cnt), 32'(e.sc));
            check({tag, ".flush"}, 32'(flush_cnt), 32'(e.fc));
        end
        @(negedge clk);
    endtask

    logic [15:0] saved_stall, saved_flush;

    initial begin
        set_idle();
        model_reset();
        rst = 1'b0;
        mem_busy = 1'b1;
        #2;
        check("rst_comb_pc_freeze",   32'(pc_freeze),   32'd1);
        check("rst_comb_pipe_freeze", 32'(pipe_freeze), 32'd1);
        check("rst_state",            32'(state),       32'd0);
        check("rst_stall_cnt",        32'(stall_cnt),   32'd0);
        check("rst_flush_cnt",        32'(flush_cnt),   32'd0);
        check("rst_mem_timeout",      32'(mem_timeout), 32'd0);
        mem_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // branch with load-use hazard present: flush only
        branch_taken = 1'b1; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dst = 4'd3; src1 = 4'd3;
        step("br_hz", 1'b1);
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd0);
        branch_taken = 1'b0;
        step("killed_slot", 1'b1);
        step("load_use", 1'b1);
        check("load_use_state", 32'(state),     32'd1);
        check("load_use_cnt",   32'(stall_cnt), 32'd1);
        step("load_use_hold", 1'b1);
        set_idle();
        step("idle0", 1'b1);

        // ALU RAW: forwarding DUT does not stall, non-forwarding DUT does
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b0; exe_dst = 4'd3; src1 = 4'd3;
        #1;
        check("nf_exe_raw_bubble", 32'(nf_id_ex_flush), 32'd1);
        step("alu_raw", 1'b1);
        exe_mem_r_en = 1'b1; exe_dst = 4'd4; src1 = 4'd0; src2 = 4'd4; two_src = 1'b0;
        step("src2_unused", 1'b1);
        two_src = 1'b1;
        step("src2_load_use", 1'b1);
        set_idle();
        step("idle1", 1'b1);

        // MEM-stage RAW via src2
        mem_wb_en = 1'b1; mem_dst = 4'd5; src2 = 4'd5; two_src = 1'b1;
        #1;
        check("nf_mem_raw_bubble", 32'(nf_id_ex_flush), 32'd1);
        check("nf_mem_raw_pcf",    32'(nf_pc_freeze),   32'd1);
        step("mem_raw_fwd", 1'b1);
        two_src = 1'b0;
        #1;
        check("nf_mem_raw_no_src2", 32'(nf_id_ex_flush), 32'd0);
        step("mem_raw_no_src2", 1'b1);
        set_idle();
        step("idle2", 1'b1);

        // long memory wait
        saved_stall = stall_cnt;
        saved_flush = flush_cnt;
        mem_busy = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            step("mem_wait", 1'b1);
            if (i == 63) check("timeout_early", 32'(mem_timeout), 32'd0);
            if (i == 65) check("timeout_set",   32'(mem_timeout), 32'd1);
        end
        mem_busy = 1'b0;
        step("mem_release", 1'b1);
        check("timeout_sticky",   32'(mem_timeout), 32'd1);
        check("wait_stall_const", 32'(stall_cnt),   32'(saved_stall));
        check("wait_flush_const", 32'(flush_cnt),   32'(saved_flush));

        // busy beats branch, then branch flushes
        mem_busy = 1'b1; branch_taken = 1'b1;
        step("busy_br", 1'b1);
        mem_busy = 1'b0;
        step("br_after_busy", 1'b1);
        check("br_after_busy_cnt", 32'(flush_cnt), 32'(saved_flush + 16'd1));
        set_idle();
        step("idle3", 1'b1);

        // saturate stall_cnt with continuous load-use
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dst = 4'd3; src1 = 4'd3;
        for (int i = 0; i < 65540; i++) step("sat_run", 1'b0);
        step("sat", 1'b1);
        check("stall_saturated", 32'(stall_cnt), 32'h0000FFFF);

        // reset in the middle of a memory wait
        mem_busy = 1'b1;
        step("pre_rst_wait", 1'b1);
        step("pre_rst_wait", 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_state",   32'(state),       32'd0);
        check("async_rst_stall",   32'(stall_cnt),   32'd0);
        check("async_rst_flush",   32'(flush_cnt),   32'd0);
        check("async_rst_timeout", 32'(mem_timeout), 32'd0);
        model_reset();
        set_idle();
        @(negedge clk);
        rst = 1'b1;
        step("post_rst_idle", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
